// File: rtl/miner_pkg.sv
// Shared constants and FSM state type for the miner work loader.
// A frame is 8 midstate words followed by 3 block-header tail words.
package miner_pkg;

   localparam int WORD_W      = 32;
   localparam int MID_WORDS   = 8;
   localparam int TAIL_WORDS  = 3;
   localparam int FRAME_WORDS = MID_WORDS + TAIL_WORDS;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      DROP    = 2'd1,
      FULL    = 2'd2
   } loader_state_e;

endpackage

// File: rtl/miner_work_loader.sv
// Assembles 32-bit work words into a shadow frame, then hands the complete
// midstate/data_tail to the hasher through a single-entry output slot.
module miner_work_loader
   import miner_pkg::loader_state_e;
   import miner_pkg::COLLECT;
   import miner_pkg::DROP;
   import miner_pkg::FULL;
   import miner_pkg::WORD_W;
   import miner_pkg::MID_WORDS;
   import miner_pkg::TAIL_WORDS;
#(
   parameter int FRAME_WORDS = 11,
   parameter int ID_W        = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [31:0]                 s_data,
   input  logic                        s_valid,
   input  logic                        s_last,
   output logic                        s_ready,
   output logic                        work_valid,
   input  logic                        work_ack,
   output logic [255:0]                midstate,
   output logic [95:0]                 data_tail,
   output logic [ID_W-1:0]             work_id,
   output logic                        err_len,
   output logic [1:0]                  state_dbg
);

   localparam int               IDX_W    = $clog2(FRAME_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

   // Handshakes: an inbound word moves on a rising edge with s_valid && s_ready;
   // s_ready depends on state only. Work is consumed on an edge with
   // work_valid && work_ack; presented values hold until then.
   loader_state_e          state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic                   err_d;
   logic                   xfer;
   logic [255:0]           sh_mid;
   logic [95:0]            sh_tail;

   assign s_ready   = (state_q != FULL);
   assign state_dbg = state_q;
   assign xfer      = (state_q == FULL) && (!work_valid || work_ack);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      err_d   = 1'b0;
      case (state_q)
         COLLECT: begin
            if (s_valid) begin
               if (s_last) begin
                  idx_d = '0;
                  if (idx_q == LAST_IDX) state_d = FULL;
                  else                   err_d   = 1'b1;
               end else if (idx_q == LAST_IDX) begin
                  // Overlong frame: flag it now, discard the rest until s_last.
                  idx_d   = '0;
                  err_d   = 1'b1;
                  state_d = DROP;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         DROP: begin
            if (s_valid && s_last) begin
               state_d = COLLECT;
               idx_d   = '0;
            end
         end
         FULL: begin
            if (xfer) state_d = COLLECT;
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= COLLECT;
         idx_q      <= '0;
         err_len    <= 1'b0;
         work_valid <= 1'b0;
         work_id    <= '0;
         midstate   <= '0;
         data_tail  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         err_len <= err_d;
         if (xfer) begin
            midstate   <= sh_mid;
            data_tail  <= sh_tail;
            work_valid <= 1'b1;
            work_id    <= work_id + ID_W'(1);
         end else if (work_ack) begin
            work_valid <= 1'b0;
         end
      end
   end

   // Shadow frame buffer carries no reset; it is fully rewritten by each frame.
   always_ff @(posedge clk) begin
      if (rst_n && state_q == COLLECT && s_valid) begin
         for (int w = 0; w < MID_WORDS; w++)
            if (idx_q == IDX_W'(w)) sh_mid[WORD_W*w +: WORD_W] <= s_data;
         for (int w = 0; w < TAIL_WORDS; w++)
            if (idx_q == IDX_W'(MID_WORDS + w)) sh_tail[WORD_W*w +: WORD_W] <= s_data;
      end
   end

endmodule

// File: tb/tb_miner_work_loader.sv
// Directed bench for miner_work_loader: framing, hand-off, errors, reset, wrap.
module tb_miner_work_loader;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [31:0]  s_data;
   logic         s_valid;
   logic         s_last;
   logic         s_ready;
   logic         work_valid;
   logic         work_ack;
   logic [255:0] midstate;
   logic [95:0]  data_tail;
   logic [7:0]   work_id;
   logic         err_len;
   logic [1:0]   state_dbg;

   int tests_run = 0;
   int tests_failed = 0;
   int err_cnt = 0;
   int wv_rise = 0;
   bit wv_prev = 1'b0;
   bit seen_zero = 1'b0;
   logic [7:0] exp_id;

   miner_work_loader #(.FRAME_WORDS(11), .ID_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
      .s_last(s_last), .s_ready(s_ready), .work_valid(work_valid),
      .work_ack(work_ack), .midstate(midstate), .data_tail(data_tail),
      .work_id(work_id), .err_len(err_len), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n) begin
         if (err_len) err_cnt++;
         if (work_valid && !wv_prev) wv_rise++;
         if (work_valid && work_id == 8'd0) seen_zero = 1'b1;
      end
      wv_prev = work_valid;
   end

   function automatic logic [31:0] word_val(input int f, input int i);
      logic [31:0] v;
      if (f == 0) v = 32'h1111_1111 * (i + 1);
      else        v = {f[7:0], 8'hA5, i[7:0], 8'h3C};
      return v;
   endfunction

   function automatic logic [255:0] exp_mid(input int f);
      logic [255:0] m;
      for (int i = 0; i < 8; i++) m[32*i +: 32] = word_val(f, i);
      return m;
   endfunction

   function automatic logic [95:0] exp_tail(input int f);
      logic [95:0] t;
      for (int i = 0; i < 3; i++) t[32*i +: 32] = word_val(f, 8 + i);
      return t;
   endfunction

   // driver tasks
   task automatic send_word(input logic [31:0] d, input logic last, output int stalls);
      s_data  = d;
      s_valid = 1'b1;
      s_last  = last;
      stalls  = 0;
      while (!s_ready && stalls < 100) begin
         @(posedge clk); #1;
         stalls++;
      end
      tests_run++;
      if (!s_ready) begin
         $display("FAIL send_word_ready: s_ready got %b expected 1 after %0d cycles", s_ready, stalls);
         tests_failed++;
      end
      @(posedge clk); #1;
   endtask

   task automatic send_frame(input int f, input int n, output int stalls);
      int s;
      stalls = 0;
      for (int i = 0; i < n; i++) begin
         send_word(word_val(f, i), (i == n - 1), s);
         stalls += s;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_work(input string name);
      int n = 0;
      while (!work_valid && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      tests_run++;
      if (!work_valid) begin
         $display("FAIL %s_timeout: work_valid got 0 expected 1", name);
         tests_failed++;
      end
   endtask

   task automatic check_work(input string name, input int f, input logic [7:0] id);
      tests_run++;
      if (midstate !== exp_mid(f)) begin
         $display("FAIL %s_midstate: got %h expected %h", name, midstate, exp_mid(f));
         tests_failed++;
      end
      tests_run++;
      if (data_tail !== exp_tail(f)) begin
         $display("FAIL %s_tail: got %h expected %h", name, data_tail, exp_tail(f));
         tests_failed++;
      end
      tests_run++;
      if (work_id !== id) begin
         $display("FAIL %s_id: got %0d expected %0d", name, work_id, id);
         tests_failed++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; work_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (work_valid !== 1'b0 || err_len !== 1'b0 || s_ready !== 1'b1) begin
         $display("FAIL reset_ctrl: wv/err/rdy got %b%b%b expected 001", work_valid, err_len, s_ready);
         tests_failed++;
      end
      tests_run++;
      if (work_id !== 8'd0 || midstate !== '0 || data_tail !== '0) begin
         $display("FAIL reset_data: id %0d mid %h tail %h expected zeros", work_id, midstate, data_tail);
         tests_failed++;
      end
      rst_n = 1'b1;
      exp_id = 8'd0;
   endtask

   task automatic test_basic();
      int s;
      work_ack = 1'b1;
      send_frame(0, 11, s);
      tests_run++;
      if (work_valid !== 1'b0 || s_ready !== 1'b0) begin
         $display("FAIL basic_full: wv/rdy got %b%b expected 00", work_valid, s_ready);
         tests_failed++;
      end
      @(posedge clk); #1;
      exp_id = exp_id + 8'd1;
      tests_run++;
      if (work_valid !== 1'b1) begin
         $display("FAIL basic_latency: work_valid got %b expected 1", work_valid);
         tests_failed++;
      end
      tests_run++;
      if (midstate[31:0] !== 32'h1111_1111 || midstate[255:224] !== 32'h8888_8888 ||
          data_tail[95:64] !== 32'hBBBB_BBBB) begin
         $display("FAIL basic_words: got %h %h %h expected 11111111 88888888 bbbbbbbb",
                  midstate[31:0], midstate[255:224], data_tail[95:64]);
         tests_failed++;
      end
      check_work("basic", 0, exp_id);
      @(posedge clk); #1;
      tests_run++;
      if (work_valid !== 1'b0) begin
         $display("FAIL basic_ack_clear: work_valid got %b expected 0", work_valid);
         tests_failed++;
      end
      work_ack = 1'b0;
   endtask

   task automatic test_back_to_back();
      int s;
      int bad = 0;
      work_ack = 1'b0;
      send_frame(2, 11, s);
      send_frame(3, 11, s);
      exp_id = exp_id + 8'd1;
      for (int c = 0; c < 30; c++) begin
         if (work_valid !== 1'b1 || s_ready !== 1'b0 || midstate !== exp_mid(2) ||
             data_tail !== exp_tail(2) || work_id !== exp_id) bad++;
         @(posedge clk); #1;
      end
      tests_run++;
      if (bad != 0) begin
         $display("FAIL b2b_hold: unstable cycles got %0d expected 0", bad);
         tests_failed++;
      end
      work_ack = 1'b1;
      @(posedge clk); #1;
      work_ack = 1'b0;
      exp_id = exp_id + 8'd1;
      tests_run++;
      if (work_valid !== 1'b1) begin
         $display("FAIL b2b_valid_kept: work_valid got %b expected 1", work_valid);
         tests_failed++;
      end
      check_work("b2b", 3, exp_id);
      @(posedge clk); #1;
      tests_run++;
      if (work_valid !== 1'b1 || s_ready !== 1'b1) begin
         $display("FAIL b2b_after: wv/rdy got %b%b expected 11", work_valid, s_ready);
         tests_failed++;
      end
      work_ack = 1'b1;
      @(posedge clk); #1;
      work_ack = 1'b0;
      tests_run++;
      if (work_valid !== 1'b0) begin
         $display("FAIL b2b_clear: work_valid got %b expected 0", work_valid);
         tests_failed++;
      end
   endtask

   task automatic test_short_frame();
      int s;
      int e0 = err_cnt;
      int w0 = wv_rise;
      work_ack = 1'b1;
      send_frame(4, 5, s);
      tests_run++;
      if (err_len !== 1'b1) begin
         $display("FAIL short_err: err_len got %b expected 1", err_len);
         tests_failed++;
      end
      @(posedge clk); #1;
      tests_run++;
      if (err_len !== 1'b0 || work_valid !== 1'b0) begin
         $display("FAIL short_pulse: err/wv got %b%b expected 00", err_len, work_valid);
         tests_failed++;
      end
      send_frame(5, 11, s);
      wait_work("short");
      exp_id = exp_id + 8'd1;
      check_work("short_next", 5, exp_id);
      @(posedge clk); #1;
      tests_run++;
      if (err_cnt - e0 != 1 || wv_rise - w0 != 1) begin
         $display("FAIL short_counts: err/work got %0d/%0d expected 1/1", err_cnt - e0, wv_rise - w0);
         tests_failed++;
      end
      work_ack = 1'b0;
   endtask

   task automatic test_long_frame();
      int s;
      int e0 = err_cnt;
      int w0 = wv_rise;
      work_ack = 1'b1;
      for (int i = 0; i < 13; i++) begin
         send_word(word_val(6, i), (i == 12), s);
         if (i == 10) begin
            tests_run++;
            if (err_len !== 1'b1) begin
               $display("FAIL long_err: err_len got %b expected 1", err_len);
               tests_failed++;
            end
         end
      end
      s_valid = 1'b0; s_last = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (err_cnt - e0 != 1 || wv_rise - w0 != 0 || work_valid !== 1'b0) begin
         $display("FAIL long_drop: err/work/wv got %0d/%0d/%b expected 1/0/0",
                  err_cnt - e0, wv_rise - w0, work_valid);
         tests_failed++;
      end
      send_frame(7, 11, s);
      wait_work("long");
      exp_id = exp_id + 8'd1;
      check_work("long_next", 7, exp_id);
      @(posedge clk); #1;
      work_ack = 1'b0;
   endtask

   task automatic test_reset_midframe();
      int s;
      for (int i = 0; i < 6; i++) send_word(word_val(8, i), 1'b0, s);
      s_data = 32'hDEAD_BEEF; s_valid = 1'b1; s_last = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      tests_run++;
      if (s_ready !== 1'b1 || work_valid !== 1'b0 || work_id !== 8'd0 || midstate !== '0) begin
         $display("FAIL rst_mid_state: rdy/wv/id got %b/%b/%0d expected 1/0/0", s_ready, work_valid, work_id);
         tests_failed++;
      end
      rst_n = 1'b1;
      s_valid = 1'b0;
      exp_id = 8'd0;
      work_ack = 1'b1;
      send_frame(9, 11, s);
      wait_work("rst_mid");
      exp_id = exp_id + 8'd1;
      check_work("rst_mid", 9, exp_id);
      @(posedge clk); #1;
   endtask

   task automatic test_wrap();
      int s;
      int max_stall = 0;
      int w0;
      work_ack = 1'b1;
      @(posedge clk); #1;
      seen_zero = 1'b0;
      w0 = wv_rise;
      for (int f = 0; f < 256; f++) begin
         send_frame(10 + (f % 200), 11, s);
         if (s > max_stall) max_stall = s;
      end
      wait_work("wrap");
      exp_id = exp_id + 8'd0;
      check_work("wrap_last", 10 + (255 % 200), exp_id);
      @(posedge clk); #1;
      tests_run++;
      if (max_stall > 1) begin
         $display("FAIL wrap_stall: max stall got %0d expected <=1", max_stall);
         tests_failed++;
      end
      tests_run++;
      if (!seen_zero || wv_rise - w0 != 256) begin
         $display("FAIL wrap_count: seen_zero/works got %b/%0d expected 1/256", seen_zero, wv_rise - w0);
         tests_failed++;
      end
      work_ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_short_frame();
      test_long_frame();
      test_reset_midframe();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
